key_debounce: RTL and testbench

//  Upstream stage of the signal generator's frequency-control path. Conditions raw, bouncy,

---
 rtl/key_debounce_pkg.sv | 29 ++
 rtl/key_debounce_ch.sv | 134 +++++++++++++
 rtl/key_debounce.sv | 36 +++
 tb/tb_key_debounce.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared definitions for the key debouncer: channel FSM states, board-clock
// timing defaults and the counter sizing helper.
package key_debounce_pkg;

  typedef enum logic [2:0] {
    KD_IDLE     = 3'd0,
    KD_PRESS_DB = 3'd1,
    KD_HELD     = 3'd2,
    KD_REPEAT   = 3'd3,
    KD_REL_DB   = 3'd4
  } kd_state_e;

  // Defaults for the 50 MHz board clock: 20 ms debounce, 500 ms first repeat, 100 ms repeat.
  localparam int unsigned KD_DEBOUNCE_CYC_DEF      = 1_000_000;
  localparam int unsigned KD_REPEAT_DELAY_CYC_DEF  = 25_000_000;
  localparam int unsigned KD_REPEAT_PERIOD_CYC_DEF = 5_000_000;

  // One counter per channel is reused for all three intervals, so size it for the longest.
  function automatic int unsigned kdCntWidth(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce/auto-repeat FSM and a shared
// interval counter, with registered level and pulse outputs.
module key_debounce_ch
  import key_debounce_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC      = KD_DEBOUNCE_CYC_DEF,
  parameter int unsigned REPEAT_DELAY_CYC  = KD_REPEAT_DELAY_CYC_DEF,
  parameter int unsigned REPEAT_PERIOD_CYC = KD_REPEAT_PERIOD_CYC_DEF,
  parameter bit          REPEAT_EN         = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n_i,
  output logic level_o,
  output logic press_n_o,
  output logic release_o
);

  localparam int CNT_W = int'(kdCntWidth(DEBOUNCE_CYC, REPEAT_DELAY_CYC, REPEAT_PERIOD_CYC));

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [1:0]       sync_q;
  logic             pressed;
  kd_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             pressN_q, pressN_d;
  logic             release_q, release_d;

  // Synchronizer resets to the released level so a held key is re-debounced after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_n_i};
    end
  end

  assign pressed = ~sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= KD_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      pressN_q  <= 1'b1;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      pressN_q  <= pressN_d;
      release_q <= release_d;
    end
  end

  // Any disagreement with the expected level restarts the relevant interval.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    pressN_d  = 1'b1;
    release_d = 1'b0;
    case (state_q)
      KD_IDLE: begin
        if (pressed) begin
          state_d = KD_PRESS_DB;
          cnt_d   = '0;
        end
      end
      KD_PRESS_DB: begin
        if (!pressed) begin
          state_d = KD_IDLE;
        end else if (cnt_q == DB_LAST) begin
          state_d  = KD_HELD;
          cnt_d    = '0;
          level_d  = 1'b1;
          pressN_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      KD_HELD: begin
        if (!pressed) begin
          state_d = KD_REL_DB;
          cnt_d   = '0;
        end else if (REPEAT_EN && (cnt_q == RD_LAST)) begin
          state_d  = KD_REPEAT;
          cnt_d    = '0;
          pressN_d = 1'b0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      KD_REPEAT: begin
        if (!pressed) begin
          state_d = KD_REL_DB;
          cnt_d   = '0;
        end else if (cnt_q == RP_LAST) begin
          cnt_d    = '0;
          pressN_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      KD_REL_DB: begin
        if (pressed) begin
          state_d = KD_HELD;
          cnt_d   = '0;
        end else if (cnt_q == DB_LAST) begin
          state_d   = KD_IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = KD_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign level_o   = level_q;
  assign press_n_o = pressN_q;
  assign release_o = release_q;

endmodule

// File: rtl/key_debounce.sv
// Debounces NUM_KEYS active-low push-buttons into one-cycle press/repeat and
// release pulses for the frequency-word stepper; channels are independent.
module key_debounce
  import key_debounce_pkg::*;
#(
  parameter int unsigned NUM_KEYS          = 2,
  parameter int unsigned DEBOUNCE_CYC      = KD_DEBOUNCE_CYC_DEF,
  parameter int unsigned REPEAT_DELAY_CYC  = KD_REPEAT_DELAY_CYC_DEF,
  parameter int unsigned REPEAT_PERIOD_CYC = KD_REPEAT_PERIOD_CYC_DEF,
  parameter bit          REPEAT_EN         = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_in_n,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press_n,
  output logic [NUM_KEYS-1:0] key_release
);

  for (genvar k = 0; k < int'(NUM_KEYS); k++) begin : gCh
    key_debounce_ch #(
      .DEBOUNCE_CYC      (DEBOUNCE_CYC),
      .REPEAT_DELAY_CYC  (REPEAT_DELAY_CYC),
      .REPEAT_PERIOD_CYC (REPEAT_PERIOD_CYC),
      .REPEAT_EN         (REPEAT_EN)
    ) uCh (
      .clk       (clk),
      .reset     (reset),
      .key_n_i   (key_in_n[k]),
      .level_o   (key_level[k]),
      .press_n_o (key_press_n[k]),
      .release_o (key_release[k])
    );
  end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: vector table, multi-cycle hand sequences and a
// randomized run against an event-counting reference model.
module tb_key_debounce;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RP = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] key_in_n = 2'b11;
  logic [1:0] key_level, key_press_n, key_release;

  int  checks = 0;
  int  fails = 0;
  bit  modelCheck = 1'b0;

  key_debounce #(
    .NUM_KEYS          (2),
    .DEBOUNCE_CYC      (DB),
    .REPEAT_DELAY_CYC  (RD),
    .REPEAT_PERIOD_CYC (RP),
    .REPEAT_EN         (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_in_n    (key_in_n),
    .key_level   (key_level),
    .key_press_n (key_press_n),
    .key_release (key_release)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] keys;
    logic [1:0] pressN;
    logic [1:0] level;
    logic [1:0] rel;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(input logic [1:0] keys, input logic [1:0] pressN,
                                 input logic [1:0] level, input logic [1:0] rel, input int n);
    for (int i = 0; i < n; i++) vecs.push_back('{keys, pressN, level, rel});
  endfunction

  task automatic checkOutput(input string name, input logic [1:0] actual, input logic [1:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  function automatic string listStr(input int q[$]);
    string s;
    s = "";
    foreach (q[i]) s = {s, $sformatf(" %0d", q[i])};
    return (q.size() == 0) ? " none" : s;
  endfunction

  task automatic checkQueue(input string name, input int got[$], input int expQ[$]);
    bit same;
    checks++;
    same = (got.size() == expQ.size());
    if (same) foreach (got[i]) if (got[i] != expQ[i]) same = 1'b0;
    if (!same) begin
      fails++;
      $display("[TB] FAIL %s: got windows%s, expected windows%s", name, listStr(got), listStr(expQ));
    end
  endtask

  // Drive at a falling edge; the next rising edge samples it and outputs are viewed one falling edge later.
  task automatic applyStimulus(input logic [1:0] keys);
    key_in_n = keys;
    @(negedge clk);
  endtask

  // Reference model: counts consecutive agreeing samples and the age of the current hold.
  logic [1:0] mHist1, mHist2;
  logic [1:0] expPressN, expLevel, expRel;
  int         oneRun[2], zeroRun[2], holdStart[2];
  int         edgeNum, mAge;
  logic       mS;

  task automatic modelReset();
    mHist1 = 2'b11; mHist2 = 2'b11;
    expPressN = 2'b11; expLevel = 2'b00; expRel = 2'b00;
    edgeNum = 0;
    for (int k = 0; k < 2; k++) begin
      oneRun[k] = 0; zeroRun[k] = 0; holdStart[k] = 0;
    end
  endtask

  initial begin
    modelReset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        modelReset();
      end else begin
        for (int k = 0; k < 2; k++) begin
          mS = ~mHist2[k];
          expPressN[k] = 1'b1;
          expRel[k]    = 1'b0;
          if (!expLevel[k]) begin
            if (mS) begin
              oneRun[k]++;
              if (oneRun[k] == DB + 1) begin
                expPressN[k] = 1'b0;
                expLevel[k]  = 1'b1;
                holdStart[k] = edgeNum;
                zeroRun[k]   = 0;
              end
            end else begin
              oneRun[k] = 0;
            end
          end else if (mS) begin
            if (zeroRun[k] > 0) begin
              zeroRun[k]   = 0;
              holdStart[k] = edgeNum;
            end else begin
              mAge = edgeNum - holdStart[k];
              if (mAge >= RD && ((mAge - RD) % RP) == 0) expPressN[k] = 1'b0;
            end
          end else begin
            zeroRun[k]++;
            if (zeroRun[k] == DB + 1) begin
              expLevel[k] = 1'b0;
              expRel[k]   = 1'b1;
              oneRun[k]   = 0;
            end
          end
        end
        mHist2 = mHist1;
        mHist1 = key_in_n;
        edgeNum++;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (modelCheck) begin
        checkOutput("rand press_n", key_press_n, expPressN);
        checkOutput("rand level", key_level, expLevel);
        checkOutput("rand release", key_release, expRel);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         p0[$], p1[$], r0[$], r1[$], expQ[$];
    int         holdLeft[2];
    logic [1:0] randKeys;
    logic [1:0] keys;

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("reset press_n", key_press_n, 2'b11);
      checkOutput("reset level", key_level, 2'b00);
      checkOutput("reset release", key_release, 2'b00);
    end
    reset = 1'b0;

    // Clean press/release, then a bounced press (low 3, high 1, low) and its release.
    addVec(2'b10, 2'b11, 2'b00, 2'b00, 6);
    addVec(2'b10, 2'b10, 2'b01, 2'b00, 1);
    addVec(2'b10, 2'b11, 2'b01, 2'b00, 3);
    addVec(2'b11, 2'b11, 2'b01, 2'b00, 6);
    addVec(2'b11, 2'b11, 2'b00, 2'b01, 1);
    addVec(2'b11, 2'b11, 2'b00, 2'b00, 3);
    addVec(2'b10, 2'b11, 2'b00, 2'b00, 3);
    addVec(2'b11, 2'b11, 2'b00, 2'b00, 1);
    addVec(2'b10, 2'b11, 2'b00, 2'b00, 6);
    addVec(2'b10, 2'b10, 2'b01, 2'b00, 1);
    addVec(2'b10, 2'b11, 2'b01, 2'b00, 3);
    addVec(2'b11, 2'b11, 2'b01, 2'b00, 6);
    addVec(2'b11, 2'b11, 2'b00, 2'b01, 1);
    addVec(2'b11, 2'b11, 2'b00, 2'b00, 3);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].keys);
      checkOutput($sformatf("vec%0d press_n", i), key_press_n, vecs[i].pressN);
      checkOutput($sformatf("vec%0d level", i), key_level, vecs[i].level);
      checkOutput($sformatf("vec%0d release", i), key_release, vecs[i].rel);
    end

    p0.delete(); p1.delete(); r0.delete();
    for (int w = 0; w < 80; w++) begin
      keys = (w < 60) ? 2'b10 : 2'b11;
      applyStimulus(keys);
      if (!key_press_n[0]) p0.push_back(w);
      if (!key_press_n[1]) p1.push_back(w);
      if (key_release[0]) r0.push_back(w);
    end
    expQ = '{6, 26, 34, 42, 50, 58};
    checkQueue("hold press key0", p0, expQ);
    expQ = '{66};
    checkQueue("hold release key0", r0, expQ);
    expQ.delete();
    checkQueue("hold press key1", p1, expQ);
    checkOutput("hold end level", key_level, 2'b00);

    p0.delete(); p1.delete(); r0.delete(); r1.delete();
    for (int w = 0; w < 38; w++) begin
      keys = (w < 10) ? 2'b00 : 2'b10;
      applyStimulus(keys);
      if (w == 6) checkOutput("simultaneous press_n", key_press_n, 2'b00);
      if (!key_press_n[0]) p0.push_back(w);
      if (!key_press_n[1]) p1.push_back(w);
      if (key_release[0]) r0.push_back(w);
      if (key_release[1]) r1.push_back(w);
    end
    expQ = '{6, 26, 34};
    checkQueue("dual press key0", p0, expQ);
    expQ = '{6};
    checkQueue("dual press key1", p1, expQ);
    expQ = '{16};
    checkQueue("dual release key1", r1, expQ);
    expQ.delete();
    checkQueue("dual release key0", r0, expQ);
    checkOutput("dual end level", key_level, 2'b01);

    // Key 0 is now auto-repeating; reset must clear outputs without waiting for a clock.
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async reset press_n", key_press_n, 2'b11);
    checkOutput("async reset level", key_level, 2'b00);
    checkOutput("async reset release", key_release, 2'b00);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    p0.delete();
    for (int w = 0; w < 10; w++) begin
      applyStimulus(2'b10);
      if (!key_press_n[0]) p0.push_back(w);
    end
    expQ = '{6};
    checkQueue("post-reset press key0", p0, expQ);
    checkOutput("post-reset level", key_level, 2'b01);
    for (int w = 0; w < 10; w++) applyStimulus(2'b11);

    modelCheck = 1'b1;
    holdLeft[0] = 0;
    holdLeft[1] = 0;
    randKeys = 2'b11;
    for (int c = 0; c < 700; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (holdLeft[k] == 0) begin
          randKeys[k] = 1'($urandom_range(0, 1));
          holdLeft[k] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 5))
                                                     : int'($urandom_range(6, 45));
        end
        holdLeft[k]--;
      end
      applyStimulus(randKeys);
    end
    modelCheck = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
